// File: rtl/nios_pio_in.sv
// Avalon-MM input PIO: synchronises in_port, captures per-bit edges, raises a level irq.
// Optional define NIOS_PIO_IN_BITCLR_EN: address-3 writes clear only the bits written as 1.
module nios_pio_in #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q, sync_dly_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] edge_term;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_mask, wr_clr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    assign wr_mask = chipselect & ~write_n & (address == 2'd2);
    assign wr_clr  = chipselect & ~write_n & (address == 2'd3);

    always_comb begin
        edge_term = '0;
        if (EDGE_TYPE == 0) begin
            edge_term = sync2_q & ~sync_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_term = ~sync2_q & sync_dly_q;
        end else begin
            edge_term = sync2_q ^ sync_dly_q;
        end
    end

    always_comb begin
        clr_bits = '0;
`ifdef NIOS_PIO_IN_BITCLR_EN
        if (wr_clr) clr_bits = writedata[WIDTH-1:0];
`else
        if (wr_clr) clr_bits = {WIDTH{1'b1}};
`endif
        // New edges are OR-ed in after the clear so a coincident edge survives it.
        capture_d = (capture_q & ~clr_bits) | edge_term;
        mask_d    = wr_mask ? writedata[WIDTH-1:0] : mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = sync2_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_dly_q <= '0;
            mask_q     <= RESET_MASK[WIDTH-1:0];
            capture_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            sync_dly_q <= sync2_q;
            mask_q     <= mask_d;
            capture_q  <= capture_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_nios_pio_in.sv
// Directed bench for nios_pio_in: rising-edge instance (dut) and falling-edge instance (dut_f).
module tb_nios_pio_in;

    localparam logic [7:0] RMASK = 8'h3C;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [7:0]  in_port_f;
    logic [31:0] readdata;
    logic [31:0] readdata_f;
    logic        irq;
    logic        irq_f;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] in_val;
        logic [7:0] mask_val;
        logic [7:0] exp_cap;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[7];

    nios_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .RESET_MASK({24'h0, RMASK})) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h0)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_f),
        .readdata(readdata_f), .irq(irq_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        d          = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic [7:0]  exp_d;

    initial begin
        vecs[0] = '{8'h05, 8'h04, 8'h05, 1'b1};
        vecs[1] = '{8'h0F, 8'h01, 8'h0A, 1'b0};
        vecs[2] = '{8'hF0, 8'h80, 8'hF0, 1'b1};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'h00, 1'b0};
        vecs[6] = '{8'h55, 8'h55, 8'h55, 1'b1};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        in_port_f  = 8'h00;

        #2;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        do_read(2'd3, rd); chk("rst_capture", rd, 32'h0);
        do_read(2'd2, rd); chk("rst_mask", rd, {24'h0, RMASK});
        do_read(2'd0, rd); chk("rst_data", rd, 32'h0);
        chk("rst_irq_after", {31'h0, irq}, 32'h0);

        // Synchroniser latency and capture timing
        do_write(2'd2, 32'h04);
        address    = 2'd0;
        chipselect = 1'b1;
        in_port    = 8'h05;
        tick();
        chk("lat_rd_c1", readdata, 32'h0);
        tick();
        chk("lat_rd_c2", readdata, 32'h0);
        chk("lat_irq_c2", {31'h0, irq}, 32'h0);
        tick();
        chk("lat_rd_c3", readdata, 32'h05);
        chk("lat_irq_c3", {31'h0, irq}, 32'h1);
        chipselect = 1'b0;
        do_read(2'd3, rd); chk("lat_capture", rd, 32'h05);

        // Mask write: same-cycle read sees old value, irq follows mask immediately
        do_write(2'd2, 32'h00);
        chk("wr_rd_old_mask", readdata, 32'h04);
        chk("mask0_irq", {31'h0, irq}, 32'h0);
        do_read(2'd3, rd); chk("mask0_capture", rd, 32'h05);
        do_write(2'd2, 32'hFF);
        chk("maskff_irq", {31'h0, irq}, 32'h1);

        // Capture clear with writedata 0x01
        do_write(2'd3, 32'h01);
`ifdef NIOS_PIO_IN_BITCLR_EN
        exp_d = 8'h04;
`else
        exp_d = 8'h00;
`endif
        do_read(2'd3, rd); chk("clr_capture", rd, {24'h0, exp_d});
        chk("clr_irq", {31'h0, irq}, {31'h0, |exp_d});

        // Writes to addresses 0 and 1 have no effect
        do_write(2'd0, 32'h00);
        do_write(2'd1, 32'h00);
        do_read(2'd2, rd); chk("ign_mask", rd, 32'hFF);
        do_read(2'd1, rd); chk("rsvd_read", rd, 32'h0);
        do_read(2'd3, rd); chk("ign_capture", rd, {24'h0, exp_d});

        // Edge coincident with clear: set wins
        do_write(2'd3, 32'hFF);
        in_port = 8'h04;
        idle(4);
        do_read(2'd3, rd); chk("sw_pre_capture", rd, 32'h0);
        in_port = 8'h05;
        idle(2);
        do_write(2'd3, 32'h01);
        chk("sw_irq", {31'h0, irq}, 32'h1);
        do_read(2'd3, rd); chk("sw_capture", rd, 32'h01);
        do_write(2'd3, 32'h01);
        do_read(2'd3, rd); chk("sw_later_clear", rd, 32'h0);
        chk("sw_later_irq", {31'h0, irq}, 32'h0);

        // Table-driven vectors
        in_port = 8'h00;
        idle(4);
        for (int i = 0; i < 7; i++) begin
            do_write(2'd3, 32'hFF);
            do_write(2'd2, {24'h0, vecs[i].mask_val});
            in_port = vecs[i].in_val;
            idle(4);
            do_read(2'd0, rd); chk($sformatf("vec%0d_data", i), rd, {24'h0, vecs[i].in_val});
            do_read(2'd3, rd); chk($sformatf("vec%0d_cap", i), rd, {24'h0, vecs[i].exp_cap});
            do_read(2'd2, rd); chk($sformatf("vec%0d_mask", i), rd, {24'h0, vecs[i].mask_val});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Falling-edge instance
        do_write(2'd3, 32'hFF);
        in_port_f = 8'h01;
        idle(4);
        address = 2'd3; chipselect = 1'b1; tick(); chipselect = 1'b0;
        chk("fall_rise_ignored", readdata_f, 32'h0);
        in_port_f = 8'h00;
        idle(4);
        address = 2'd3; chipselect = 1'b1; tick(); chipselect = 1'b0;
        chk("fall_captured", readdata_f, 32'h01);
        do_write(2'd3, 32'hFF);
        in_port_f = 8'h01;
        idle(4);
        address = 2'd3; chipselect = 1'b1; tick(); chipselect = 1'b0;
        chk("fall_rise_again", readdata_f, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
